ex3_to_bcd_dec: RTL and testbench

EX3_TO_BCD_DEC -- requirements
Module: ex3_to_bcd_dec

---
 rtl/ex3_pkg.sv | 14 +
 rtl/ex3_digit_dec.sv | 24 ++
 rtl/ex3_to_bcd_dec.sv | 117 +++++++++++
 tb/tb_ex3_to_bcd_dec.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex3_pkg.sv
// Shared constants and FSM encoding for the excess-3 to BCD word decoder.
package ex3_pkg;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] EX3_MIN    = 4'd3;
  localparam logic [3:0] EX3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex3_digit_dec.sv
// Single-digit excess-3 to BCD decoder; the invalid-code flag is only built
// when DETECT_EN is set, otherwise it is a constant 0.
module ex3_digit_dec
  import ex3_pkg::*;
#(
  parameter bit DETECT_EN = 1'b0
) (
  input  logic [3:0] i_ex3,
  output logic [3:0] o_bcd,
  output logic       o_invalid
);

  // Mod-16 wrap is intentional: invalid codes still yield a defined nibble.
  assign o_bcd = i_ex3 - EX3_OFFSET;

  generate
    if (DETECT_EN) begin : g_detect
      assign o_invalid = (i_ex3 < EX3_MIN) || (i_ex3 > EX3_MAX);
    end else begin : g_no_detect
      assign o_invalid = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ex3_to_bcd_dec.sv
// Serial excess-3 to BCD word decoder: one digit per cycle, valid/ready on both
// sides. Define EX3_ERR_DETECT_EN to enable the sticky invalid-digit flag.
module ex3_to_bcd_dec
  import ex3_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] in_ex3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] out_bcd,
  output logic                  out_err
);

  localparam int W     = 4 * N_DIGITS;
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

`ifdef EX3_ERR_DETECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_word;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_bcd;
  logic [W-1:0]     w_acc_next;
  logic [3:0]       w_digit;
  logic [3:0]       w_bcd;
  logic             w_invalid;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LAST);
  assign w_digit  = r_word[{r_cnt, 2'b00} +: 4];

  ex3_digit_dec #(
    .DETECT_EN (ERR_EN)
  ) u_digit_dec (
    .i_ex3     (w_digit),
    .o_bcd     (w_bcd),
    .o_invalid (w_invalid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = CONV;
      CONV:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_cnt, 2'b00} +: 4] = w_bcd;
  end

  // Results build in r_acc so out_bcd only changes when a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_acc  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_word <= in_ex3;
      r_cnt  <= '0;
    end else if (r_state == CONV) begin
      r_acc <= w_acc_next;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_bcd <= w_acc_next;
    end
  end

  assign out_bcd = r_bcd;

`ifdef EX3_ERR_DETECT_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_err <= 1'b0;
    else if (w_accept)          r_err <= 1'b0;
    else if (r_state == CONV)   r_err <= r_err | w_invalid;
  end

  assign out_err = r_err;
`else
  // Detection is not built; the sub-module drives a constant 0 here.
  assign out_err = w_invalid;
`endif

endmodule

// File: tb/tb_ex3_to_bcd_dec.sv
// Scoreboard bench for ex3_to_bcd_dec: directed vectors plus random words
// checked against an arithmetic reference model.
module tb_ex3_to_bcd_dec;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_ex3 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_bcd;
  logic         out_err;

  typedef struct {
    logic [W-1:0] bcd;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t bp_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = -1;
  int   prev_accept = -1;
  bit   prev_valid = 1'b0;
  bit   rand_bp = 1'b0;

  ex3_to_bcd_dec #(.N_DIGITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ex3    (in_ex3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    e.bcd = '0;
    e.err = 1'b0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(w[4*i +: 4]);
      e.bcd[4*i +: 4] = 4'((d - 3 + 16) % 16);
`ifdef EX3_ERR_DETECT_EN
      if (d < 3 || d > 12) e.err = 1'b1;
`endif
    end
    return e;
  endfunction

  // Monitor: latency on each out_valid rise, compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid && accept_cyc >= 0)
        check("latency", cyc - accept_cyc, N);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", out_bcd);
        end else begin
          mon_e = sb.pop_front();
          check("out_bcd", out_bcd, mon_e.bcd);
          check("out_err", out_err, mon_e.err);
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom % 4) != 0;
    end
  end

  task automatic send(input logic [W-1:0] w, input bit hold);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_ex3   = w;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(w));
        prev_accept = accept_cyc;
        accept_cyc  = cyc + 1;
        done        = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: word %h not accepted", w);
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_ex3   = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: %0d words outstanding", sb.size());
    end
  endtask

  initial begin
    bit seen;
    logic [W-1:0] w;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bcd", out_bcd, 0);
    check("rst_out_err", out_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    send(16'h4B7C, 1'b0);
    wait_idle();
    check("single_cycle_valid", out_valid, 0);
    send(16'h3C3C, 1'b0);
    wait_idle();
    send(16'h3F33, 1'b0);
    wait_idle();

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    w = 16'h6A59;
    bp_e = model(w);
    send(w, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bp_valid_timeout: out_valid never rose");
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_bcd", out_bcd, bp_e.bcd);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      in_valid = 1'($urandom % 2);
      in_ex3   = W'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_one_handshake", sb.size(), 0);

    // Reset during the second CONV cycle discards the word.
    send(16'h4444, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    accept_cyc = -1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_bcd", out_bcd, 0);
    check("midrst_out_err", out_err, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'h5555, 1'b0);
    wait_idle();

    send(16'h4444, 1'b1);
    send(16'h3456, 1'b0);
    check("accept_spacing", accept_cyc - prev_accept, N + 2);
    wait_idle();

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = '0;
      for (int d = 0; d < N; d++)
        w[4*d +: 4] = ($urandom % 8 == 0) ? 4'($urandom) : 4'($urandom_range(3, 12));
      send(w, (i < 39) && ($urandom % 2 == 1));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
